// File: rtl/retire_commit.sv
// In-order retirement: commits the ROB head into the retirement RAT and frees the displaced physical register.
// On a mispredicted head it flushes, walks the squashed entries back to the free list, then restores the rename RAT.
module retire_commit #(
  parameter int PHYSREGS_DEPTH = 6,
  parameter int RENRAT_DEPTH   = 32,
  parameter int ROB_DATAWIDTH  = 12
) (
  input  logic                                     CLK,
  input  logic                                     RESET,
  input  logic                                     FREEZE,
  input  logic                                     fROB_empty_IN,
  input  logic [ROB_DATAWIDTH-1:0]                 fROB_headData_IN,
  input  logic                                     fROB_headDone_IN,
  input  logic                                     fROB_headMispredict_IN,
  output logic                                     tROB_popReq_OUT,
  input  logic                                     fFreeL_full_IN,
  output logic                                     tFreeL_pushReq_OUT,
  output logic [PHYSREGS_DEPTH-1:0]                tFreeL_pushData_OUT,
  output logic                                     tRenRatOverwrite_OUT,
  output logic [PHYSREGS_DEPTH*RENRAT_DEPTH-1:0]   tRenRatOverwriteData_OUT,
  output logic                                     tFlush_OUT,
  output logic                                     tStall_OUT,
  output logic [31:0]                              tRetireCount_OUT
);

  localparam int ARCH_W = (RENRAT_DEPTH > 1) ? $clog2(RENRAT_DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WALK    = 2'd1,
    ST_RESTORE = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [ARCH_W-1:0]         head_arch_s;
  logic [PHYSREGS_DEPTH-1:0] head_phys_s;
  logic                      head_dreq_s;
  logic                      commit_s;
  logic                      walk_pop_s;
  logic                      rrat_we_s;
  logic                      push_d, push_q;
  logic [PHYSREGS_DEPTH-1:0] push_data_d, push_data_q;
  logic                      flush_d, flush_q;
  logic                      ovw_d, ovw_q;
  logic [31:0]               count_q;
  logic [PHYSREGS_DEPTH-1:0] rrat_q [RENRAT_DEPTH];

  assign head_arch_s = fROB_headData_IN[ARCH_W-1:0];
  assign head_phys_s = fROB_headData_IN[ARCH_W +: PHYSREGS_DEPTH];
  assign head_dreq_s = fROB_headData_IN[ARCH_W + PHYSREGS_DEPTH];

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (commit_s && fROB_headMispredict_IN) state_d = ST_WALK;
        else                                    state_d = ST_RUN;
      end
      ST_WALK: begin
        if (!FREEZE && fROB_empty_IN) state_d = ST_RESTORE;
        else                          state_d = ST_WALK;
      end
      ST_RESTORE: begin
        if (!FREEZE) state_d = ST_RUN;
        else         state_d = ST_RESTORE;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Per-state pop qualification and stall
  always_comb begin
    commit_s   = 1'b0;
    walk_pop_s = 1'b0;
    tStall_OUT = 1'b0;
    case (state_q)
      ST_RUN: begin
        commit_s = !FREEZE && !fROB_empty_IN && fROB_headDone_IN && !fFreeL_full_IN;
      end
      ST_WALK: begin
        walk_pop_s = !FREEZE && !fROB_empty_IN && !fFreeL_full_IN;
        tStall_OUT = 1'b1;
      end
      ST_RESTORE: begin
        tStall_OUT = 1'b1;
      end
      default: begin
        tStall_OUT = 1'b0;
      end
    endcase
  end

  assign tROB_popReq_OUT = commit_s | walk_pop_s;

  // Free-list push selection: a commit to x0 frees its own register rather than touching the RAT
  always_comb begin
    push_d      = 1'b0;
    push_data_d = '0;
    rrat_we_s   = 1'b0;
    flush_d     = commit_s && fROB_headMispredict_IN;
    ovw_d       = (state_q == ST_WALK) && !FREEZE && fROB_empty_IN;
    if (commit_s && head_dreq_s) begin
      push_d      = 1'b1;
      rrat_we_s   = (head_arch_s != '0);
      push_data_d = rrat_we_s ? rrat_q[head_arch_s] : head_phys_s;
    end else if (walk_pop_s && head_dreq_s) begin
      push_d      = 1'b1;
      push_data_d = head_phys_s;
    end else begin
      push_d      = 1'b0;
    end
  end

  // Retirement RAT, strobes and retire counter
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      push_q      <= 1'b0;
      push_data_q <= '0;
      flush_q     <= 1'b0;
      ovw_q       <= 1'b0;
      count_q     <= 32'd0;
      for (int i = 0; i < RENRAT_DEPTH; i++) begin
        rrat_q[i] <= PHYSREGS_DEPTH'(i);
      end
    end else begin
      push_q      <= push_d;
      push_data_q <= push_data_d;
      flush_q     <= flush_d;
      ovw_q       <= ovw_d;
      if (commit_s) count_q <= count_q + 32'd1;
      if (rrat_we_s) rrat_q[head_arch_s] <= head_phys_s;
    end
  end

  // Packed view of the retirement RAT
  always_comb begin
    tRenRatOverwriteData_OUT = '0;
    for (int i = 0; i < RENRAT_DEPTH; i++) begin
      tRenRatOverwriteData_OUT[i*PHYSREGS_DEPTH +: PHYSREGS_DEPTH] = rrat_q[i];
    end
  end

  assign tFreeL_pushReq_OUT   = push_q;
  assign tFreeL_pushData_OUT  = push_data_q;
  assign tFlush_OUT           = flush_q;
  assign tRenRatOverwrite_OUT = ovw_q;
  assign tRetireCount_OUT     = count_q;

endmodule

// File: tb/tb_retire_commit.sv
// Scoreboarded random + directed bench for retire_commit against a spec-level retirement model.
module tb_retire_commit;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         FREEZE = 1'b0;
  logic         fROB_empty_IN = 1'b1;
  logic [11:0]  fROB_headData_IN = 12'd0;
  logic         fROB_headDone_IN = 1'b0;
  logic         fROB_headMispredict_IN = 1'b0;
  logic         tROB_popReq_OUT;
  logic         fFreeL_full_IN = 1'b0;
  logic         tFreeL_pushReq_OUT;
  logic [5:0]   tFreeL_pushData_OUT;
  logic         tRenRatOverwrite_OUT;
  logic [191:0] tRenRatOverwriteData_OUT;
  logic         tFlush_OUT;
  logic         tStall_OUT;
  logic [31:0]  tRetireCount_OUT;

  retire_commit dut (
    .CLK                      (CLK),
    .RESET                    (RESET),
    .FREEZE                   (FREEZE),
    .fROB_empty_IN            (fROB_empty_IN),
    .fROB_headData_IN         (fROB_headData_IN),
    .fROB_headDone_IN         (fROB_headDone_IN),
    .fROB_headMispredict_IN   (fROB_headMispredict_IN),
    .tROB_popReq_OUT          (tROB_popReq_OUT),
    .fFreeL_full_IN           (fFreeL_full_IN),
    .tFreeL_pushReq_OUT       (tFreeL_pushReq_OUT),
    .tFreeL_pushData_OUT      (tFreeL_pushData_OUT),
    .tRenRatOverwrite_OUT     (tRenRatOverwrite_OUT),
    .tRenRatOverwriteData_OUT (tRenRatOverwriteData_OUT),
    .tFlush_OUT               (tFlush_OUT),
    .tStall_OUT               (tStall_OUT),
    .tRetireCount_OUT         (tRetireCount_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         cyc;
    logic [5:0] data;
  } push_t;

  push_t      pq[$];
  int         fq[$];
  int         oq[$];
  int         cyc_mon = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  // Reference model: mode 0 = running, 1 = walking squashed entries, 2 = restoring
  int          m_mode;
  logic [5:0]  m_rrat [32];
  logic [31:0] m_count;

  function automatic logic [191:0] m_pack();
    logic [191:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) v[i*6 +: 6] = m_rrat[i];
    return v;
  endfunction

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_count = 32'd0;
    for (int i = 0; i < 32; i++) m_rrat[i] = 6'(i);
    pq.delete();
    fq.delete();
    oq.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b0;
    FREEZE = 1'b0; fROB_empty_IN = 1'b1; fROB_headDone_IN = 1'b0;
    fROB_headMispredict_IN = 1'b0; fFreeL_full_IN = 1'b0; fROB_headData_IN = 12'd0;
    #1;
    model_reset();
    chk("rst_stall", {191'd0, tStall_OUT}, 192'd0);
    chk("rst_pop", {191'd0, tROB_popReq_OUT}, 192'd0);
    chk("rst_push", {191'd0, tFreeL_pushReq_OUT}, 192'd0);
    chk("rst_flush", {191'd0, tFlush_OUT}, 192'd0);
    chk("rst_ovw", {191'd0, tRenRatOverwrite_OUT}, 192'd0);
    chk("rst_count", {160'd0, tRetireCount_OUT}, 192'd0);
    chk("rst_rrat", tRenRatOverwriteData_OUT, m_pack());
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
  endtask

  // One clock of stimulus; the model decides what the coming edge must do
  task automatic cycle(input logic e, input logic d, input logic mp, input logic f,
                       input logic fr, input logic [4:0] a, input logic [5:0] p, input logic dr);
    logic exp_pop;
    @(negedge CLK);
    fROB_empty_IN = e; fROB_headDone_IN = d; fROB_headMispredict_IN = mp;
    fFreeL_full_IN = f; FREEZE = fr; fROB_headData_IN = {dr, p, a};
    #1;
    exp_pop = 1'b0;
    if (!fr) begin
      case (m_mode)
        0: if (!e && d && !f) begin
          exp_pop = 1'b1;
          m_count = m_count + 32'd1;
          if (dr) begin
            if (a != 5'd0) begin
              pq.push_back('{cyc_mon + 1, m_rrat[a]});
              m_rrat[a] = p;
            end else begin
              pq.push_back('{cyc_mon + 1, p});
            end
          end
          if (mp) begin
            fq.push_back(cyc_mon + 1);
            m_mode = 1;
          end
        end
        1: if (e) begin
          m_mode = 2;
          oq.push_back(cyc_mon + 1);
        end else if (!f) begin
          exp_pop = 1'b1;
          if (dr) pq.push_back('{cyc_mon + 1, p});
        end
        2: m_mode = 0;
        default: m_mode = 0;
      endcase
    end
    chk("pop", {191'd0, tROB_popReq_OUT}, {191'd0, exp_pop});
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 1'b0);
  endtask

  // Monitor: compares registered outputs after each edge against queued expectations
  always @(posedge CLK) begin
    #1;
    cyc_mon++;
    while (pq.size() > 0 && pq[0].cyc < cyc_mon) begin
      chk("push_missing", 192'd0, {186'd0, pq[0].data});
      void'(pq.pop_front());
    end
    if (tFreeL_pushReq_OUT) begin
      if (pq.size() > 0 && pq[0].cyc == cyc_mon) begin
        chk("push_data", {186'd0, tFreeL_pushData_OUT}, {186'd0, pq[0].data});
        void'(pq.pop_front());
      end else begin
        chk("push_spurious", 192'd1, 192'd0);
      end
    end
    if (fq.size() > 0 && fq[0] == cyc_mon) begin
      chk("flush", {191'd0, tFlush_OUT}, 192'd1);
      void'(fq.pop_front());
    end else begin
      chk("flush", {191'd0, tFlush_OUT}, 192'd0);
    end
    if (oq.size() > 0 && oq[0] == cyc_mon) begin
      chk("overwrite", {191'd0, tRenRatOverwrite_OUT}, 192'd1);
      void'(oq.pop_front());
    end else begin
      chk("overwrite", {191'd0, tRenRatOverwrite_OUT}, 192'd0);
    end
    chk("rrat", tRenRatOverwriteData_OUT, m_pack());
    chk("count", {160'd0, tRetireCount_OUT}, {160'd0, m_count});
    chk("stall", {191'd0, tStall_OUT}, {191'd0, logic'(m_mode != 0)});
  end

  initial begin
    model_reset();
    do_reset();

    // Commit arch 3 -> phys 40, frees old phys 3
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 6'd40, 1'b1);
    idle();
    chk("r39_count", {160'd0, tRetireCount_OUT}, 192'd1);
    chk("r39_rrat3", {186'd0, tRenRatOverwriteData_OUT[23:18]}, 192'd40);

    // Commit to x0 frees its own register
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'd33, 1'b1);
    idle();
    chk("r40_rrat0", {186'd0, tRenRatOverwriteData_OUT[5:0]}, 192'd0);

    // Mispredict followed by three squashed entries, then restore
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 6'd20, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd6, 6'd41, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 6'd50, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 6'd42, 1'b1);
    idle();
    idle();
    idle();
    chk("r41_run", {191'd0, tStall_OUT}, 192'd0);

    // Free list full for 5 cycles, then commit
    repeat (5) cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 6'd11, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 6'd11, 1'b1);
    idle();

    // Freeze for 3 cycles with a ready head
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd10, 6'd12, 1'b1);
    idle();

    // Reset dropped in the middle of a walk
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 6'd22, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 6'd23, 1'b1);
    do_reset();
    idle();

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 7) == 0), 5'($urandom), 6'($urandom),
              ($urandom_range(0, 3) != 0));
      end
    end

    repeat (6) idle();
    chk("drain_push", {160'd0, 32'(pq.size())}, 192'd0);
    chk("drain_flush", {160'd0, 32'(fq.size())}, 192'd0);
    chk("drain_ovw", {160'd0, 32'(oq.size())}, 192'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/retire_commit.md
RETIRE_COMMIT -- requirements
Module: retire_commit

Interface
REQ-001 Parameter PHYSREGS_DEPTH, default 6, SHALL be the width of a physical register index.
REQ-002 Parameter RENRAT_DEPTH, default 32, SHALL be the number of architectural registers.
REQ-003 Parameter ROB_DATAWIDTH, default 12, SHALL be the width of the ROB head entry.
REQ-004 CLK  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 RESET  in  1  SHALL be asynchronous and active-low, and SHALL apply the reset state immediately while low.
REQ-006 FREEZE  in  1  SHALL, when high, hold all state and deassert all request outputs.
REQ-007 fROB_empty_IN  in  1  SHALL indicate that the ROB is empty.
REQ-008 fROB_headData_IN  in  ROB_DATAWIDTH  SHALL carry the head entry: [4:0] archDest, [10:5] physDest, [11] destReqd.
REQ-009 fROB_headDone_IN  in  1  SHALL indicate that the head entry has completed execution.
REQ-010 fROB_headMispredict_IN  in  1  SHALL indicate that the head entry is a mispredicted branch or jump.
REQ-011 tROB_popReq_OUT  out  1  SHALL be a combinational pop strobe for the ROB head.
REQ-012 fFreeL_full_IN  in  1  SHALL indicate that the free list is full.
REQ-013 tFreeL_pushReq_OUT  out  1  SHALL be the registered free-list push strobe.
REQ-014 tFreeL_pushData_OUT  out  PHYSREGS_DEPTH  SHALL be the physical register being freed.
REQ-015 tRenRatOverwrite_OUT  out  1  SHALL be a one-cycle, registered rename-RAT restore strobe.
REQ-016 tRenRatOverwriteData_OUT  out  PHYSREGS_DEPTH*RENRAT_DEPTH  SHALL carry the retirement RAT, packed with entry i at [6i+5:6i].
REQ-017 tFlush_OUT  out  1  SHALL be a registered one-cycle frontend flush pulse.
REQ-018 tStall_OUT  out  1  SHALL be high while the state is WALK or RESTORE.
REQ-019 tRetireCount_OUT  out  32  SHALL count retired instructions and wrap modulo 2^32.

Function
REQ-020 The block SHALL implement states RUN, WALK and RESTORE, with RUN as the reset state.
REQ-021 A commit condition SHALL be: state==RUN, !FREEZE, !fROB_empty_IN, fROB_headDone_IN and !fFreeL_full_IN.
REQ-022 tROB_popReq_OUT SHALL equal the commit condition in RUN, or the walk condition in WALK (REQ-027), and SHALL otherwise be 0.
REQ-023 On commit with destReqd=1 and archDest!=0, the block SHALL set RRAT[archDest] to physDest and, on the next cycle, push the old RRAT[archDest] to the free list.
REQ-024 On commit with destReqd=1 and archDest==0, the block SHALL leave the RRAT unchanged and push physDest itself on the next cycle.
REQ-025 On commit with destReqd=0, the block SHALL push nothing and leave the RRAT unchanged.
REQ-026 Commit SHALL increment tRetireCount_OUT by 1. A committed head with fROB_headMispredict_IN=1 SHALL also pulse tFlush_OUT on the next cycle and move the state to WALK.
REQ-027 The walk condition SHALL be: state==WALK, !FREEZE, !fROB_empty_IN and !fFreeL_full_IN; the done bit SHALL be ignored.
REQ-028 In WALK, each popped squashed entry with destReqd=1 SHALL have its physDest pushed on the next cycle; the RRAT and the retire count SHALL NOT change.
REQ-029 In WALK with fROB_empty_IN=1, the state SHALL move to RESTORE.
REQ-030 In RESTORE, the block SHALL drive tRenRatOverwriteData_OUT from the RRAT, pulse tRenRatOverwrite_OUT for exactly one cycle, and return to RUN on the next edge.
REQ-031 Every free-list push SHALL have a latency of exactly 1 cycle from its pop, with at most one push per cycle.
REQ-032 tFreeL_pushReq_OUT SHALL be 0 in any cycle not following a qualifying pop.
REQ-033 FREEZE SHALL hold the state; a push already registered SHALL still appear for one cycle.
REQ-034 fFreeL_full_IN high SHALL stall both commit and walk; no free-list push SHALL ever be dropped.
REQ-035 tRenRatOverwriteData_OUT SHALL continuously reflect the registered RRAT contents.

Reset
REQ-036 While RESET is low, RRAT[i] SHALL be i for all i.
REQ-037 While RESET is low, the state SHALL be RUN, and all strobes and tRetireCount_OUT SHALL be 0.
REQ-038 A reset asserted mid-WALK SHALL abandon the walk, with no restore pulse issued.

Verification
REQ-039 Reset, then a head with arch 3, phys 40, destReqd, done -> pop in cycle 0; the cycle-1 push carries data 3; RRAT[3]=40; count=1.
REQ-040 A head with arch 0, phys 33, destReqd -> push 33; RRAT[0] stays 0.
REQ-041 A mispredict head with 3 squashed entries behind it (phys 41, none, 42) -> flush pulse, then 3 walk pops, then pushes of 41 and 42, then one overwrite pulse carrying the RRAT, then RUN.
REQ-042 fFreeL_full_IN held high for 5 cycles with a ready head -> no pop and no push; commit occurs on the first cycle after full drops.
REQ-043 RESET dropped during WALK -> immediate RUN state, RRAT at identity, no overwrite pulse.
REQ-044 FREEZE high for 3 cycles during RUN with a ready head -> no pop, and count and RRAT are unchanged.
